seg7_scan_ctrl: RTL and testbench
=================================

Name: seg7_scan_ctrl

Overview:
Parametrised multiplexed 7-segment display controller; successor to the fixed 8-digit board driver. Scans N_DIGITS common-anode digits from a double-buffered hex frame. Adds per-digit decimal points, blanking, blinking, leading-zero suppression, PWM brightness and tear-free frame loading. Sits between the CPU debug/IO registers and the board anode/segment pins.

Parameters:
N_DIGITS, 8, number of digits scanned (2..16)
SCAN_DIV, 131072, clk cycles per digit slot (>=2)
PWM_BITS, 4, brightness resolution
BLINK_FRAMES, 64, full frames per blink half-period (>=1)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
load  in  1  capture data/dp/blank_mask/blink_mask into staging
data  in  4*N_DIGITS  hex nibble per digit, digit 0 = bits [3:0]
dp  in  N_DIGITS  decimal point request per digit, 1 = lit
blank_mask  in  N_DIGITS  1 = digit forced dark
blink_mask  in  N_DIGITS  1 = digit blinks
lz_en  in  1  leading-zero suppression enable
brightness  in  PWM_BITS  duty setting, all-ones = full on
an  out  N_DIGITS  anode selects, active-low
a2g  out  7  segments g..a (bit0 = a), active-low
dp_n  out  1  decimal point, active-low
frame_done  out  1  one-cycle pulse at end of each full scan

Behaviour:
- Reset (reset=0, async): an all ones, a2g 7'h7F, dp_n 1, frame_done 0; prescaler, digit index, PWM counter, frame counter, blink phase, staging, active registers all 0; pending flag 0.
- Prescaler counts 0..SCAN_DIV-1; slot tick at SCAN_DIV-1, wraps to 0.
- Digit index advances on tick; N_DIGITS-1 wraps to 0 (frame boundary); frame_done pulses for the cycle the wrap is registered.
- load=1: staging <= inputs, pending <= 1. At frame boundary with pending=1: active <= staging, pending <= 0. Load in same cycle as boundary: transfer uses pre-load staging; new capture stays pending for next boundary. lz_en, brightness are live (not buffered).
- PWM counter: free-running PWM_BITS wrap counter. Digit lit when brightness all-ones, or pwm_cnt < brightness. brightness 0 = always dark.
- Frame counter counts boundaries 0..BLINK_FRAMES-1; at wrap blink phase toggles. Blink digit dark while phase=1.
- Leading-zero suppression (lz_en=1): digit k dark if active nibbles k..N_DIGITS-1 all zero, k>=1; digit 0 never suppressed. Suppressed digit's dp still shown if dp bit set (an low, a2g 7F).
- Dark conditions: blank_mask, blink-off, PWM off -> an all ones, a2g 7F, dp_n 1.
- Segment glyphs (active-low, g..a): 0=40,1=79,2=24,3=30,4=19,5=12,6=02,7=78,8=00,9=10,A=08,b=03,C=46,d=21,E=06,F=0E (hex).
- an, a2g, dp_n registered: reflect index/PWM/mask state of previous cycle (1-cycle latency). Exactly one an bit low when lit.
- Reset mid-scan: outputs dark immediately (async), scan restarts at digit 0 after release; staged-not-transferred data lost.

Test Plan:
- N_DIGITS=4, SCAN_DIV=4, brightness=F, load data=16'h12AF once -> after first boundary an cycles E,D,B,7 each 4 cycles, a2g 0E,08,24,79; frame_done every 16 cycles.
- Load 16'h1234 then 16'h5678 mid-frame -> current frame finishes showing old value, next frame shows 8,7,6,5 only; no mixed frame.
- lz_en=1, data=16'h0030 -> digits 3,2 dark (an never 7 or B lit), digit1=30, digit0=40; data=0 -> only digit0 shows 40.
- brightness=4, PWM_BITS=4, SCAN_DIV=16 -> each slot an low exactly 4 of 16 cycles; brightness=0 -> an stays all ones.
- BLINK_FRAMES=2, blink_mask=4'b0001 -> digit0 lit frames 0-1, dark 2-3, lit 4-5; others unaffected; dp=4'b0010 -> dp_n 0 only in digit1 slot.
- Assert reset low mid-slot -> an=F, a2g=7F same cycle; release -> restart digit 0, active data 0 (displays 40).

Source files
------------

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed common-anode 7-segment scanner with a double-buffered frame,
// per-digit dp/blank/blink, leading-zero suppression and PWM brightness.
module seg7_scan_ctrl #(
    parameter int N_DIGITS     = 8,
    parameter int SCAN_DIV     = 131072,
    parameter int PWM_BITS     = 4,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [4*N_DIGITS-1:0] data,
    input  logic [N_DIGITS-1:0]   dp,
    input  logic [N_DIGITS-1:0]   blank_mask,
    input  logic [N_DIGITS-1:0]   blink_mask,
    input  logic                  lz_en,
    input  logic [PWM_BITS-1:0]   brightness,
    output logic [N_DIGITS-1:0]   an,
    output logic [6:0]            a2g,
    output logic                  dp_n,
    output logic                  frame_done
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(N_DIGITS);
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [PW-1:0]         presc;
    logic [IW-1:0]         idx;
    logic [PWM_BITS-1:0]   pwm_cnt;
    logic [FW-1:0]         frame_cnt;
    logic                  blink_phase;

    logic [4*N_DIGITS-1:0] stg_data, act_data;
    logic [N_DIGITS-1:0]   stg_dp, act_dp;
    logic [N_DIGITS-1:0]   stg_blank, act_blank;
    logic [N_DIGITS-1:0]   stg_blink, act_blink;
    logic                  pending;

    logic                  tick;
    logic                  wrap;

    assign tick = (presc == PW'(SCAN_DIV - 1));
    assign wrap = tick && (idx == IW'(N_DIGITS - 1));

    // Scan timing: prescaler, digit index, PWM phase and blink cadence.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc       <= '0;
            idx         <= '0;
            pwm_cnt     <= '0;
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else begin
            presc   <= tick ? '0 : presc + 1'b1;
            pwm_cnt <= pwm_cnt + 1'b1;
            if (tick) begin
                idx <= (idx == IW'(N_DIGITS - 1)) ? '0 : idx + 1'b1;
            end
            if (wrap) begin
                if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
                    frame_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
        end
    end

    // load is a one-cycle strobe with no back-pressure; a capture that lands
    // on the frame boundary waits for the next boundary so frames never mix.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stg_data  <= '0;
            stg_dp    <= '0;
            stg_blank <= '0;
            stg_blink <= '0;
            act_data  <= '0;
            act_dp    <= '0;
            act_blank <= '0;
            act_blink <= '0;
            pending   <= 1'b0;
        end else begin
            if (wrap && pending) begin
                act_data  <= stg_data;
                act_dp    <= stg_dp;
                act_blank <= stg_blank;
                act_blink <= stg_blink;
            end
            if (load) begin
                stg_data  <= data;
                stg_dp    <= dp;
                stg_blank <= blank_mask;
                stg_blink <= blink_mask;
                pending   <= 1'b1;
            end else if (wrap) begin
                pending <= 1'b0;
            end
        end
    end

    function automatic logic [6:0] glyph(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0: g = 7'h40;
            4'h1: g = 7'h79;
            4'h2: g = 7'h24;
            4'h3: g = 7'h30;
            4'h4: g = 7'h19;
            4'h5: g = 7'h12;
            4'h6: g = 7'h02;
            4'h7: g = 7'h78;
            4'h8: g = 7'h00;
            4'h9: g = 7'h10;
            4'hA: g = 7'h08;
            4'hB: g = 7'h03;
            4'hC: g = 7'h46;
            4'hD: g = 7'h21;
            4'hE: g = 7'h06;
            default: g = 7'h0E;
        endcase
        return g;
    endfunction

    // lz_zero[k]: every active nibble from k up to the top digit is zero.
    logic [N_DIGITS-1:0] lz_zero;
    logic                upper_zero;

    always_comb begin
        lz_zero    = '0;
        upper_zero = 1'b1;
        for (int k = N_DIGITS - 1; k >= 0; k--) begin
            upper_zero = upper_zero && (act_data[4*k +: 4] == 4'd0);
            lz_zero[k] = upper_zero;
        end
    end

    logic [3:0]          nib;
    logic                pwm_on;
    logic                dark;
    logic                suppress;
    logic [N_DIGITS-1:0] sel_n;
    logic [N_DIGITS-1:0] an_nxt;
    logic [6:0]          a2g_nxt;
    logic                dp_n_nxt;

    always_comb begin
        nib      = act_data[{idx, 2'b00} +: 4];
        pwm_on   = (&brightness) || (pwm_cnt < brightness);
        dark     = act_blank[idx] || (act_blink[idx] && blink_phase) || !pwm_on;
        suppress = lz_en && (idx != '0) && lz_zero[idx];
        sel_n    = ~(N_DIGITS'(1) << idx);
        an_nxt   = '1;
        a2g_nxt  = 7'h7F;
        dp_n_nxt = 1'b1;
        if (!dark) begin
            if (suppress) begin
                // A suppressed zero still carries its decimal point.
                if (act_dp[idx]) begin
                    an_nxt   = sel_n;
                    dp_n_nxt = 1'b0;
                end
            end else begin
                an_nxt   = sel_n;
                a2g_nxt  = glyph(nib);
                dp_n_nxt = ~act_dp[idx];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            an         <= '1;
            a2g        <= 7'h7F;
            dp_n       <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            an         <= an_nxt;
            a2g        <= a2g_nxt;
            dp_n       <= dp_n_nxt;
            frame_done <= wrap;
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl: cycle-count reference model with an
// expected queue, random loads/masks/brightness, plus literal anchor checks.
module tb_seg7_scan_ctrl;

    localparam int N   = 4;
    localparam int SD  = 16;
    localparam int PB  = 4;
    localparam int BF  = 2;
    localparam int FRM = N * SD;
    localparam int W   = N + 7 + 1 + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          load;
    logic [4*N-1:0] data;
    logic [N-1:0]  dp, blank_mask, blink_mask;
    logic          lz_en;
    logic [PB-1:0] brightness;
    logic [N-1:0]  an;
    logic [6:0]    a2g;
    logic          dp_n;
    logic          frame_done;

    int chk = 0;
    int err = 0;

    seg7_scan_ctrl #(
        .N_DIGITS(N), .SCAN_DIV(SD), .PWM_BITS(PB), .BLINK_FRAMES(BF)
    ) dut (
        .clk(clk), .reset(rst_n), .load(load), .data(data), .dp(dp),
        .blank_mask(blank_mask), .blink_mask(blink_mask), .lz_en(lz_en),
        .brightness(brightness), .an(an), .a2g(a2g), .dp_n(dp_n),
        .frame_done(frame_done)
    );

    // clock / reset
    always #5 clk = ~clk;

    // reference model state
    logic [6:0] glyph_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                   7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    int             cp;
    logic [4*N-1:0] m_stg_data, m_act_data;
    logic [N-1:0]   m_stg_dp, m_act_dp, m_stg_blank, m_act_blank, m_stg_blink, m_act_blink;
    logic           m_pend;
    logic [W-1:0]   exp_q[$];
    localparam logic [W-1:0] RESET_OUT = {{N{1'b1}}, 7'h7F, 1'b1, 1'b0};

    // Outputs after the edge that ends cycle c (c cycles since reset release).
    function automatic logic [W-1:0] model_out(int c, logic lz, logic [PB-1:0] br);
        int         i, pwm, frame;
        logic       phase, lit, dark, supp, fd;
        logic [N-1:0] an_e;
        logic [6:0] seg_e;
        logic       dpn_e;
        i     = (c / SD) % N;
        pwm   = c % (1 << PB);
        frame = c / FRM;
        phase = ((frame / BF) % 2) == 1;
        lit   = (br == {PB{1'b1}}) || (pwm < int'(br));
        dark  = m_act_blank[i] || (m_act_blink[i] && phase) || !lit;
        supp  = lz && (i >= 1) && ((m_act_data >> (4 * i)) == 0);
        fd    = ((c + 1) % FRM) == 0;
        an_e  = '1;
        seg_e = 7'h7F;
        dpn_e = 1'b1;
        if (!dark) begin
            if (supp) begin
                if (m_act_dp[i]) begin
                    an_e  = ~(N'(1) << i);
                    dpn_e = 1'b0;
                end
            end else begin
                an_e  = ~(N'(1) << i);
                seg_e = glyph_tab[(m_act_data >> (4 * i)) & 4'hF];
                dpn_e = ~m_act_dp[i];
            end
        end
        return {an_e, seg_e, dpn_e, fd};
    endfunction

    initial forever begin
        @(negedge rst_n);
        cp = 0;
        m_stg_data = '0; m_act_data = '0;
        m_stg_dp = '0; m_act_dp = '0;
        m_stg_blank = '0; m_act_blank = '0;
        m_stg_blink = '0; m_act_blink = '0;
        m_pend = 1'b0;
        exp_q.delete();
    end

    initial forever begin
        @(posedge clk);
        if (rst_n === 1'b1) begin
            exp_q.push_back(model_out(cp, lz_en, brightness));
            cp++;
            if ((cp % FRM) == 0 && m_pend) begin
                m_act_data = m_stg_data; m_act_dp = m_stg_dp;
                m_act_blank = m_stg_blank; m_act_blink = m_stg_blink;
                m_pend = 1'b0;
            end
            if (load) begin
                m_stg_data = data; m_stg_dp = dp;
                m_stg_blank = blank_mask; m_stg_blink = blink_mask;
                m_pend = 1'b1;
            end
        end
    end

    // scoreboard compare on the inactive edge
    initial forever begin
        logic [W-1:0] e;
        @(negedge clk);
        if (rst_n !== 1'b1 || exp_q.size() == 0) e = RESET_OUT;
        else e = exp_q.pop_front();
        chk++;
        if ({an, a2g, dp_n, frame_done} !== e) begin
            err++;
            $display("FAIL scan t=%0t an=%h/%h a2g=%h/%h dp_n=%b/%b fd=%b/%b (got/exp)",
                     $time, an, e[W-1 -: N], a2g, e[8:2], dp_n, e[1], frame_done, e[0]);
        end
    end

    // driver / literal-check tasks
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk++;
        if (act !== exp) begin
            err++;
            $display("FAIL %s got %h exp %h", name, act, exp);
        end
    endtask

    task automatic drive_load(input logic [4*N-1:0] d, input logic [N-1:0] p,
                              input logic [N-1:0] bl, input logic [N-1:0] bk);
        @(negedge clk);
        load = 1'b1; data = d; dp = p; blank_mask = bl; blink_mask = bk;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_fd();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_done !== 1'b1 && n < 4 * FRM);
        chk++;
        if (frame_done !== 1'b1) begin
            err++;
            $display("FAIL frame_done_timeout got 0 exp 1 after %0d cycles", n);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int cnt;
        rst_n = 1'b0; load = 1'b0; data = '0; dp = '0;
        blank_mask = '0; blink_mask = '0; lz_en = 1'b0; brightness = '1;
        step(3);
        check("reset_an", an, 32'hF);
        #2 rst_n = 1'b1;

        // frame 12AF appears whole after the first boundary
        drive_load(16'h12AF, 4'h0, 4'h0, 4'h0);
        wait_fd();
        step(1);
        check("d0_an", an, 32'hE);  check("d0_seg", a2g, 32'h0E);
        step(SD);
        check("d1_an", an, 32'hD);  check("d1_seg", a2g, 32'h08);
        step(SD);
        check("d2_an", an, 32'hB);  check("d2_seg", a2g, 32'h24);
        step(SD);
        check("d3_an", an, 32'h7);  check("d3_seg", a2g, 32'h79);
        wait_fd();
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (frame_done !== 1'b1 && cnt < 4 * FRM);
        check("frame_period", cnt, FRM);

        // two loads in one frame: only the later one is ever shown
        drive_load(16'h1234, 4'h0, 4'h0, 4'h0);
        drive_load(16'h5678, 4'h0, 4'h0, 4'h0);
        wait_fd();
        step(1);
        check("dbl_d0_seg", a2g, 32'h00);

        // leading-zero suppression
        lz_en = 1'b1;
        drive_load(16'h0030, 4'h0, 4'h0, 4'h0);
        wait_fd();
        step(1);
        check("lz_d0", {an, 1'b0, a2g}, {4'hE, 8'h40});
        step(SD);
        check("lz_d1", {an, 1'b0, a2g}, {4'hD, 8'h30});
        step(SD);
        check("lz_d2_dark", an, 32'hF);
        step(SD);
        check("lz_d3_dark", an, 32'hF);
        drive_load(16'h0000, 4'h0, 4'h0, 4'h0);
        wait_fd();
        step(1);
        check("lz0_d0", {an, 1'b0, a2g}, {4'hE, 8'h40});
        step(SD);
        check("lz0_d1_dark", an, 32'hF);
        lz_en = 1'b0;

        // PWM duty
        brightness = 4'd4;
        cnt = 0;
        for (int i = 0; i < SD; i++) begin
            @(negedge clk);
            if (an !== 4'hF) cnt++;
        end
        check("pwm4_duty", cnt, 4);
        brightness = 4'd0;
        step(1);
        cnt = 0;
        for (int i = 0; i < FRM; i++) begin
            @(negedge clk);
            if (an !== 4'hF) cnt++;
        end
        check("pwm0_dark", cnt, 0);
        brightness = '1;

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            load = 1'b0;
            if ($urandom_range(0, 19) == 0) begin
                load = 1'b1;
                data = 16'($urandom);
                dp = 4'($urandom);
                blank_mask = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
                blink_mask = 4'($urandom);
                if ($urandom_range(0, 3) == 0) data[15:8] = 8'h00;
            end
            if ($urandom_range(0, 99) == 0) lz_en = 1'($urandom);
            if ($urandom_range(0, 199) == 0)
                brightness = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom);
        end
        load = 1'b0;

        // reset mid-slot: dark at once, restart at digit 0 with cleared data
        brightness = '1;
        drive_load(16'h9999, 4'hF, 4'h0, 4'h0);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("rst_async", {an, 1'b0, a2g}, {4'hF, 8'h7F});
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("rst_restart", {an, 1'b0, a2g, 3'b0, dp_n}, {4'hE, 8'h40, 4'h1});

        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            load = ($urandom_range(0, 15) == 0);
            data = 16'($urandom);
            dp = 4'($urandom);
            blank_mask = 4'h0;
            blink_mask = 4'($urandom);
            lz_en = 1'($urandom);
        end
        load = 1'b0;
        step(2);

        $display("CHECKS %0d ERRORS %0d", chk, err);
        $finish;
    end

endmodule
